// File: rtl/output_holder.sv
// Two-entry elastic byte holder between the cipher core and the chip output mux.
// Each byte is held stable until a synchronised rising edge on the acknowledge pin.
package output_holder_pkg;
    typedef enum logic [1:0] {
        O_EMPTY = 2'd0,
        O_READY = 2'd1,
        O_ACKED = 2'd2
    } output_holder_state_t;
endpackage

// state   | meaning
// O_EMPTY | nothing buffered, data_out parked at 0
// O_READY | head byte presented, waiting for an ack rising edge
// O_ACKED | head just popped, waiting for the ack pin to drop
module output_holder
    import output_holder_pkg::*;
#(
    parameter int ACK_SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           cipher_byte,
    input  logic                 cipher_valid,
    output logic                 holder_ready,
    input  logic                 output_acknowledge,
    output logic [7:0]           data_out,
    output output_holder_state_t output_holder_state,
    output logic                 overflow
);

    logic [7:0]                 mem [2];
    logic                       head;
    logic                       tail;
    logic [1:0]                 count;
    logic [ACK_SYNC_STAGES-1:0] ack_sync;
    logic                       ack_d;

    logic                 ack_s;
    logic                 ack_rise;
    logic                 push;
    logic                 pop;
    logic [1:0]           count_next;
    logic                 head_next;
    logic [7:0]           head_byte_next;
    output_holder_state_t state_next;

    assign ack_s      = ack_sync[ACK_SYNC_STAGES-1];
    assign ack_rise   = ack_s & ~ack_d;
    assign push       = cipher_valid & holder_ready;
    assign pop        = (output_holder_state == O_READY) & ack_rise;
    assign count_next = count + {1'b0, push} - {1'b0, pop};
    assign head_next  = head ^ pop;

    // A byte pushed this cycle may land directly in the new head slot.
    assign head_byte_next = (push && (tail == head_next)) ? cipher_byte : mem[head_next];

    always_comb begin
        state_next = output_holder_state;
        case (output_holder_state)
            O_EMPTY: if (push) state_next = O_READY;
            O_READY: if (ack_rise) state_next = O_ACKED;
            O_ACKED: begin
                if (!ack_s) begin
                    if (count_next != 2'd0) state_next = O_READY;
                    else                    state_next = O_EMPTY;
                end
            end
            default: state_next = O_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0]              <= 8'h00;
            mem[1]              <= 8'h00;
            head                <= 1'b0;
            tail                <= 1'b0;
            count               <= 2'd0;
            ack_sync            <= '1;
            ack_d               <= 1'b1;
            holder_ready        <= 1'b1;
            overflow            <= 1'b0;
            data_out            <= 8'h00;
            output_holder_state <= O_EMPTY;
        end else begin
            ack_sync <= {ack_sync[ACK_SYNC_STAGES-2:0], output_acknowledge};
            ack_d    <= ack_s;
            if (push) begin
                mem[tail] <= cipher_byte;
                tail      <= ~tail;
            end
            if (cipher_valid && !holder_ready) overflow <= 1'b1;
            head                <= head_next;
            count               <= count_next;
            holder_ready        <= (count_next != 2'd2);
            output_holder_state <= state_next;
            data_out            <= (state_next == O_READY) ? head_byte_next : 8'h00;
        end
    end

endmodule
